// File: rtl/bp_be_aux_wb_buffer.sv
// Writeback buffer that decouples aux-pipe results from register file write ports.
// It also accumulates sticky FP exception flags for the entries it retires.
module bp_be_aux_wb_buffer #(
  parameter int unsigned dpath_width_p    = 66,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned els_p            = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  input  logic [dpath_width_p-1:0]      data_i,
  input  logic [4:0]                    fflags_i,
  input  logic [reg_addr_width_p-1:0]   rd_addr_i,
  input  logic                          irf_w_v_i,
  input  logic                          frf_w_v_i,
  input  logic                          flush_i,
  output logic                          ready_o,
  output logic                          irf_w_v_o,
  output logic                          frf_w_v_o,
  output logic [reg_addr_width_p-1:0]   w_addr_o,
  output logic [dpath_width_p-1:0]      w_data_o,
  input  logic                          w_yumi_i,
  output logic [4:0]                    fflags_acc_o,
  input  logic                          fflags_clear_i,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = $clog2(els_p + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(els_p - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(els_p);

  typedef struct packed {
    logic [dpath_width_p-1:0]    data;
    logic [4:0]                  fflags;
    logic [reg_addr_width_p-1:0] rd;
    logic                        irf;
    logic                        frf;
  } entry_t;

  entry_t          mem_q [els_p];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            head_v, head_wr, full, enq, deq;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign head_v  = (count_q != '0);
  assign head_wr = head.irf | head.frf;
  assign full    = (count_q == FullCnt);
  // Flags-only heads retire on their own after one cycle at the head; w_yumi_i is ignored for them.
  assign deq     = head_v & (head_wr ? w_yumi_i : 1'b1);
  assign enq     = v_i & ~flush_i & (~full | deq);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    // Clear applies before the retiring entry's flags are merged.
    if (deq) begin
      acc_d = (fflags_clear_i ? 5'b0 : acc_q) | head.fflags;
    end else if (fflags_clear_i) begin
      acc_d = 5'b0;
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = next_ptr(wr_ptr_q);
      if (deq) rd_ptr_d = next_ptr(rd_ptr_q);
      if (enq && !deq) count_d = count_q + CntW'(1);
      else if (!enq && deq) count_d = count_q - CntW'(1);
      if (v_i && full && !deq) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= 5'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= '{data: data_i, fflags: fflags_i, rd: rd_addr_i,
                           irf: irf_w_v_i, frf: frf_w_v_i};
    end
  end

  assign ready_o      = ~full;
  assign irf_w_v_o    = head_v & head.irf;
  assign frf_w_v_o    = head_v & head.frf;
  assign w_addr_o     = head.rd;
  assign w_data_o     = head.data;
  assign fflags_acc_o = acc_q;
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;

endmodule
